// File: rtl/residual_update_pkg.sv
// Shared types and Q16.16 complex-element constants
// for the residual update block.
package residual_update_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int Q_FRAC_BITS  = 16;
  localparam int Q_INT_BITS   = 16;
  localparam int Q_COMP_WIDTH = Q_INT_BITS + Q_FRAC_BITS;
  localparam int ELEM_WIDTH   = 2 * Q_COMP_WIDTH;

  localparam int RE_MSB = ELEM_WIDTH - 1;
  localparam int RE_LSB = Q_COMP_WIDTH;
  localparam int IM_MSB = Q_COMP_WIDTH - 1;
  localparam int IM_LSB = 0;

  localparam int ADDR_WIDTH = 20;
  localparam int UNITS      = 8;

endpackage

// File: rtl/residual_update_if.sv
// Control and vector-memory bus of the residual update block.
// master: the update engine, slave: controller plus memories.
interface residual_update_if
  import residual_update_pkg::*;
#(
  parameter int ELEMENT_WIDTH          = ELEM_WIDTH,
  parameter int MEMORIES_ADDRESS_WIDTH = ADDR_WIDTH,
  parameter int NO_OF_UNITS            = UNITS
);

  logic                                  start;
  logic [MEMORIES_ADDRESS_WIDTH-1:0]     base_address;
  logic [MEMORIES_ADDRESS_WIDTH-1:0]     vector_length;
  logic [ELEMENT_WIDTH-1:0]              alpha;
  logic [MEMORIES_ADDRESS_WIDTH-1:0]     read_address;
  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]  r_data;
  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]  p_data;
  logic                                  write_enable;
  logic [MEMORIES_ADDRESS_WIDTH-1:0]     write_address;
  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]  write_data;
  logic                                  busy;
  logic                                  finish;

  modport master (
    input  start,
    input  base_address,
    input  vector_length,
    input  alpha,
    input  r_data,
    input  p_data,
    output read_address,
    output write_enable,
    output write_address,
    output write_data,
    output busy,
    output finish
  );

  modport slave (
    output start,
    output base_address,
    output vector_length,
    output alpha,
    output r_data,
    output p_data,
    input  read_address,
    input  write_enable,
    input  write_address,
    input  write_data,
    input  busy,
    input  finish
  );

endinterface

// File: rtl/residual_update_mac_lane.sv
// One lane: registered complex multiply alpha*p, then
// saturating r - alpha*p into a registered row slice.
module complex_mac_lane
  import residual_update_pkg::*;
#(
  parameter int ELEMENT_WIDTH = ELEM_WIDTH,
  parameter int FRAC_BITS     = Q_FRAC_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cap,
  input  logic                     mul,
  input  logic                     upd,
  input  logic [ELEMENT_WIDTH-1:0] alpha,
  input  logic [ELEMENT_WIDTH-1:0] r_in,
  input  logic [ELEMENT_WIDTH-1:0] p_in,
  output logic [ELEMENT_WIDTH-1:0] r_out
);

  localparam int CW = ELEMENT_WIDTH / 2;
  localparam int MW = 2 * CW;
  localparam int SW = MW + 1;
  localparam int DW = SW + 1;

  localparam logic signed [DW-1:0] SAT_HI =
    {{(DW-CW+1){1'b0}}, {(CW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_LO =
    {{(DW-CW+1){1'b1}}, {(CW-1){1'b0}}};

  logic [ELEMENT_WIDTH-1:0] r1_q;
  logic [ELEMENT_WIDTH-1:0] p1_q;
  logic [ELEMENT_WIDTH-1:0] r2_q;

  logic signed [MW-1:0] a_re, a_im;
  logic signed [MW-1:0] p_re, p_im;
  logic signed [MW-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [SW-1:0] s_re, s_im;
  logic signed [SW-1:0] q_re, q_im;
  logic signed [SW-1:0] prod_re_q, prod_im_q;
  logic signed [DW-1:0] d_re, d_im;
  logic [CW-1:0]        o_re, o_im;

  function automatic logic signed [MW-1:0] sx(
    input logic [CW-1:0] v
  );
    return {{CW{v[CW-1]}}, v};
  endfunction

  function automatic logic [CW-1:0] sat(
    input logic signed [DW-1:0] v
  );
    if (v > SAT_HI) return SAT_HI[CW-1:0];
    if (v < SAT_LO) return SAT_LO[CW-1:0];
    return v[CW-1:0];
  endfunction

  assign a_re = sx(alpha[ELEMENT_WIDTH-1:CW]);
  assign a_im = sx(alpha[CW-1:0]);
  assign p_re = sx(p1_q[ELEMENT_WIDTH-1:CW]);
  assign p_im = sx(p1_q[CW-1:0]);

  assign m_rr = a_re * p_re;
  assign m_ii = a_im * p_im;
  assign m_ri = a_re * p_im;
  assign m_ir = a_im * p_re;

  // one extra bit keeps the sum exact before the shift
  assign s_re = {m_rr[MW-1], m_rr} - {m_ii[MW-1], m_ii};
  assign s_im = {m_ri[MW-1], m_ri} + {m_ir[MW-1], m_ir};
  assign q_re = s_re >>> FRAC_BITS;
  assign q_im = s_im >>> FRAC_BITS;

  assign d_re =
    {{(DW-CW){r2_q[ELEMENT_WIDTH-1]}}, r2_q[ELEMENT_WIDTH-1:CW]}
    - {prod_re_q[SW-1], prod_re_q};
  assign d_im =
    {{(DW-CW){r2_q[CW-1]}}, r2_q[CW-1:0]}
    - {prod_im_q[SW-1], prod_im_q};

  assign o_re = sat(d_re);
  assign o_im = sat(d_im);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_q      <= '0;
      p1_q      <= '0;
      r2_q      <= '0;
      prod_re_q <= '0;
      prod_im_q <= '0;
      r_out     <= '0;
    end else begin
      if (cap) begin
        r1_q <= r_in;
        p1_q <= p_in;
      end
      if (mul) begin
        r2_q      <= r1_q;
        prod_re_q <= q_re;
        prod_im_q <= q_im;
      end
      if (upd) r_out <= {o_re, o_im};
    end
  end

endmodule

// File: rtl/residual_update.sv
// In-place r = r - alpha*p over a range of memory rows,
// all lanes in parallel, three-stage read/multiply/write pipe.
module residual_update
  import residual_update_pkg::*;
#(
  parameter int ELEMENT_WIDTH          = ELEM_WIDTH,
  parameter int MEMORIES_ADDRESS_WIDTH = ADDR_WIDTH,
  parameter int NO_OF_UNITS            = UNITS,
  parameter int FRAC_BITS              = Q_FRAC_BITS
) (
  input logic               clk,
  input logic               reset,
  residual_update_if.master bus
);

  localparam int AW = MEMORIES_ADDRESS_WIDTH;
  localparam int EW = ELEMENT_WIDTH;
  localparam logic [AW-1:0] ONE = AW'(1);

  state_t state_q, state_d;

  logic [AW-1:0] addr_q;
  logic [AW-1:0] rem_q;
  logic [AW-1:0] a1_q;
  logic [AW-1:0] a2_q;
  logic [AW-1:0] wa_q;
  logic [EW-1:0] alpha_q;
  logic          v1_q;
  logic          v2_q;
  logic          we_q;
  logic          run;
  logic          accept;
  logic          len_zero;

  logic [NO_OF_UNITS*EW-1:0] wd;

  assign run      = (state_q == RUN);
  assign accept   = (state_q == IDLE) && bus.start;
  assign len_zero = (bus.vector_length == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = len_zero ? DONE : RUN;
      RUN:     if (rem_q == '0) state_d = DRAIN;
      DRAIN:   if (!v1_q && !v2_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      wa_q    <= '0;
      alpha_q <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      v1_q    <= run;
      v2_q    <= v1_q;
      we_q    <= v2_q;
      a1_q    <= addr_q;
      a2_q    <= a1_q;
      if (v2_q) wa_q <= a2_q;
      if (accept) alpha_q <= bus.alpha;
      // addr_q stays on the last issued row once RUN ends
      if (accept && !len_zero) begin
        addr_q <= bus.base_address;
        rem_q  <= bus.vector_length - ONE;
      end else if (run && rem_q != '0) begin
        addr_q <= addr_q + ONE;
        rem_q  <= rem_q - ONE;
      end
    end
  end

  for (genvar u = 0; u < NO_OF_UNITS; u++) begin : g_lane
    complex_mac_lane #(
      .ELEMENT_WIDTH (EW),
      .FRAC_BITS     (FRAC_BITS)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .cap   (run),
      .mul   (v1_q),
      .upd   (v2_q),
      .alpha (alpha_q),
      .r_in  (bus.r_data[u*EW +: EW]),
      .p_in  (bus.p_data[u*EW +: EW]),
      .r_out (wd[u*EW +: EW])
    );
  end

  assign bus.read_address  = addr_q;
  assign bus.write_enable  = we_q;
  assign bus.write_address = wa_q;
  assign bus.write_data    = wd;
  assign bus.busy          = (state_q == RUN) || (state_q == DRAIN);
  assign bus.finish        = (state_q == DONE);

endmodule

// File: tb/tb_residual_update.sv
// Directed bench for residual_update with a small row memory.
module tb_residual_update;

  localparam int EW = 64;
  localparam int AW = 20;
  localparam int NU = 8;
  localparam int RW = NU * EW;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  residual_update_if #(
    .ELEMENT_WIDTH          (EW),
    .MEMORIES_ADDRESS_WIDTH (AW),
    .NO_OF_UNITS            (NU)
  ) bus ();

  residual_update #(
    .ELEMENT_WIDTH          (EW),
    .MEMORIES_ADDRESS_WIDTH (AW),
    .NO_OF_UNITS            (NU),
    .FRAC_BITS              (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [RW-1:0] r_mem [32];
  logic [RW-1:0] p_mem [32];

  assign bus.r_data = r_mem[bus.read_address[4:0]];
  assign bus.p_data = p_mem[bus.read_address[4:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            wr_cyc [$];
  logic [AW-1:0] wr_addr [$];
  logic [RW-1:0] wr_data [$];
  int            fin_cyc [$];
  logic [AW-1:0] rd_addr [$];
  int            busy_n = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.write_enable) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(bus.write_address);
        wr_data.push_back(bus.write_data);
      end
      if (bus.finish) fin_cyc.push_back(cyc);
      if (bus.busy) begin
        busy_n++;
        rd_addr.push_back(bus.read_address);
      end
    end
  end

  int nvec = 0;
  int nerr = 0;

  function automatic logic [RW-1:0] rep(input logic [EW-1:0] e);
    return {NU{e}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
    fin_cyc.delete();
    rd_addr.delete();
    busy_n = 0;
  endtask

  task automatic fill_row(input int idx, input logic [EW-1:0] r,
                          input logic [EW-1:0] p);
    r_mem[idx] = rep(r);
    p_mem[idx] = rep(p);
  endtask

  // extra >= 0 pulses a stray start that many cycles after T0
  task automatic run_pass(input logic [AW-1:0] base,
                          input logic [AW-1:0] len,
                          input logic [EW-1:0] a,
                          input int extra,
                          output int t0, output bit done);
    clear_logs();
    bus.base_address  = base;
    bus.vector_length = len;
    bus.alpha         = a;
    bus.start         = 1'b1;
    tick();
    bus.start         = 1'b0;
    bus.base_address  = 20'hABCDE;
    bus.vector_length = '0;
    bus.alpha         = '1;
    t0   = cyc;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      bus.start = (i == extra);
      tick();
      if (fin_cyc.size() > 0) done = 1'b1;
    end
    bus.start = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset             = 1'b1;
    bus.start         = 1'b0;
    bus.base_address  = '0;
    bus.vector_length = '0;
    bus.alpha         = '0;
    for (int i = 0; i < 32; i++) begin
      r_mem[i] = '0;
      p_mem[i] = '0;
    end
    repeat (3) tick();
    nvec++;
    if (bus.write_enable !== 1'b0) begin
      nerr++;
      $display("FAIL reset_we: got %b want 0", bus.write_enable);
    end
    nvec++;
    if (bus.busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    nvec++;
    if (bus.finish !== 1'b0) begin
      nerr++;
      $display("FAIL reset_finish: got %b want 0", bus.finish);
    end
    nvec++;
    if (bus.read_address !== '0) begin
      nerr++;
      $display("FAIL reset_raddr: got %h want 0", bus.read_address);
    end
    nvec++;
    if (bus.write_address !== '0) begin
      nerr++;
      $display("FAIL reset_waddr: got %h want 0", bus.write_address);
    end
    nvec++;
    if (bus.write_data !== '0) begin
      nerr++;
      $display("FAIL reset_wdata: got %h want 0", bus.write_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_unit_alpha();
    int t0;
    bit done;
    fill_row(5, 64'h00030000_00020000, 64'h00010000_00010000);
    run_pass(20'd5, 20'd1, 64'h00010000_00000000, -1, t0, done);
    nvec++;
    if (!done) begin
      nerr++;
      $display("FAIL unit_timeout: got no finish want finish");
    end
    nvec++;
    if (wr_cyc.size() != 1) begin
      nerr++;
      $display("FAIL unit_nwr: got %0d want 1", wr_cyc.size());
    end
    if (wr_cyc.size() > 0) begin
      nvec++;
      if (wr_addr[0] !== 20'd5) begin
        nerr++;
        $display("FAIL unit_addr: got %h want 5", wr_addr[0]);
      end
      nvec++;
      if (wr_data[0] !== rep(64'h00020000_00010000)) begin
        nerr++;
        $display("FAIL unit_data: got %h want %h", wr_data[0],
                 rep(64'h00020000_00010000));
      end
      nvec++;
      if (wr_cyc[0] != t0 + 3) begin
        nerr++;
        $display("FAIL unit_wcyc: got %0d want %0d", wr_cyc[0], t0 + 3);
      end
    end
    nvec++;
    if (fin_cyc.size() != 1 || (done && fin_cyc[0] != t0 + 4)) begin
      nerr++;
      $display("FAIL unit_finish: got %0d pulses want 1 at %0d",
               fin_cyc.size(), t0 + 4);
    end
    nvec++;
    if (busy_n != 4) begin
      nerr++;
      $display("FAIL unit_busy: got %0d want 4", busy_n);
    end
  endtask

  task automatic test_imag_alpha(input int extra);
    int t0;
    bit done;
    for (int i = 10; i < 14; i++)
      fill_row(i, 64'h0, 64'h00010000_00000000);
    run_pass(20'd10, 20'd4, 64'h00000000_00010000, extra, t0, done);
    nvec++;
    if (!done) begin
      nerr++;
      $display("FAIL imag_timeout: got no finish want finish");
    end
    nvec++;
    if (wr_cyc.size() != 4) begin
      nerr++;
      $display("FAIL imag_nwr: got %0d want 4", wr_cyc.size());
    end
    for (int i = 0; i < 4 && i < wr_cyc.size(); i++) begin
      nvec++;
      if (wr_addr[i] !== AW'(10 + i)) begin
        nerr++;
        $display("FAIL imag_addr%0d: got %h want %h", i, wr_addr[i],
                 AW'(10 + i));
      end
      nvec++;
      if (wr_data[i] !== rep(64'h00000000_FFFF0000)) begin
        nerr++;
        $display("FAIL imag_data%0d: got %h want %h", i, wr_data[i],
                 rep(64'h00000000_FFFF0000));
      end
      nvec++;
      if (wr_cyc[i] != t0 + 3 + i) begin
        nerr++;
        $display("FAIL imag_wcyc%0d: got %0d want %0d", i, wr_cyc[i],
                 t0 + 3 + i);
      end
    end
    nvec++;
    if (busy_n != 7) begin
      nerr++;
      $display("FAIL imag_busy: got %0d want 7", busy_n);
    end
    nvec++;
    if (fin_cyc.size() != 1 || (done && fin_cyc[0] != t0 + 7)) begin
      nerr++;
      $display("FAIL imag_finish: got %0d pulses want 1 at %0d",
               fin_cyc.size(), t0 + 7);
    end
  endtask

  task automatic test_saturate();
    int t0;
    bit done;
    fill_row(20, 64'h7FFFFFFF_80000000, 64'hFFFF0000_00010000);
    run_pass(20'd20, 20'd1, 64'h00010000_00000000, -1, t0, done);
    nvec++;
    if (wr_cyc.size() != 1) begin
      nerr++;
      $display("FAIL sat_nwr: got %0d want 1", wr_cyc.size());
    end
    if (wr_cyc.size() > 0) begin
      nvec++;
      if (wr_data[0] !== rep(64'h7FFFFFFF_80000000)) begin
        nerr++;
        $display("FAIL sat_data: got %h want %h", wr_data[0],
                 rep(64'h7FFFFFFF_80000000));
      end
    end
  endtask

  task automatic test_lanes();
    int t0;
    bit done;
    logic [RW-1:0] rr, pp, ex;
    for (int l = 0; l < NU; l++) begin
      rr[l*EW +: EW] = l[0] ? 64'h12345678_9ABCDEF0 : 64'h00040000_00010000;
      pp[l*EW +: EW] = l[0] ? 64'h0 : 64'h00018000_FFFF0000;
      ex[l*EW +: EW] = l[0] ? 64'h12345678_9ABCDEF0 : 64'h00008000_00024000;
    end
    r_mem[7] = rr;
    p_mem[7] = pp;
    run_pass(20'd7, 20'd1, 64'h00020000_00008000, -1, t0, done);
    nvec++;
    if (wr_cyc.size() != 1 || wr_data[0] !== ex) begin
      nerr++;
      $display("FAIL lanes_data: got %0d writes want 1 of %h",
               wr_cyc.size(), ex);
    end
    // tiny alpha exposes floor rounding of negative products
    for (int l = 0; l < NU; l++) begin
      rr[l*EW +: EW] = 64'h00050000_00050000;
      pp[l*EW +: EW] = 64'h0;
      ex[l*EW +: EW] = 64'h00050000_00050000;
    end
    rr[0 +: 3*EW] = '0;
    pp[0*EW +: EW] = 64'hFFFFFFFF_00000000;
    pp[1*EW +: EW] = 64'h00000001_00000000;
    pp[2*EW +: EW] = 64'h00000000_FFFFFFFD;
    ex[0*EW +: EW] = 64'h00000001_00000000;
    ex[1*EW +: EW] = 64'h0;
    ex[2*EW +: EW] = 64'h00000000_00000001;
    r_mem[8] = rr;
    p_mem[8] = pp;
    run_pass(20'd8, 20'd1, 64'h00000001_00000000, -1, t0, done);
    nvec++;
    if (wr_cyc.size() != 1 || wr_data[0] !== ex) begin
      nerr++;
      $display("FAIL round_data: got %0d writes want 1 of %h",
               wr_cyc.size(), ex);
    end
  endtask

  task automatic test_zero_len();
    int t0;
    bit done;
    run_pass(20'd3, 20'd0, 64'h00010000_00000000, -1, t0, done);
    nvec++;
    if (fin_cyc.size() != 1 || (done && fin_cyc[0] != t0)) begin
      nerr++;
      $display("FAIL zero_finish: got %0d pulses want 1 at %0d",
               fin_cyc.size(), t0);
    end
    nvec++;
    if (wr_cyc.size() != 0) begin
      nerr++;
      $display("FAIL zero_nwr: got %0d want 0", wr_cyc.size());
    end
    nvec++;
    if (busy_n != 0) begin
      nerr++;
      $display("FAIL zero_busy: got %0d want 0", busy_n);
    end
  endtask

  task automatic test_wrap();
    int t0;
    bit done;
    logic [AW-1:0] ea [3];
    ea[0] = 20'hFFFFE;
    ea[1] = 20'hFFFFF;
    ea[2] = 20'h00000;
    fill_row(30, 64'h00000001_00000001, 64'h0);
    fill_row(31, 64'h00000002_00000002, 64'h0);
    fill_row(0,  64'h00000003_00000003, 64'h0);
    run_pass(20'hFFFFE, 20'd3, 64'h00010000_00000000, -1, t0, done);
    nvec++;
    if (wr_cyc.size() != 3 || rd_addr.size() < 3) begin
      nerr++;
      $display("FAIL wrap_count: got %0d writes %0d reads want 3",
               wr_cyc.size(), rd_addr.size());
    end
    for (int i = 0; i < 3 && i < wr_cyc.size() && i < rd_addr.size(); i++)
    begin
      nvec++;
      if (rd_addr[i] !== ea[i]) begin
        nerr++;
        $display("FAIL wrap_raddr%0d: got %h want %h", i, rd_addr[i], ea[i]);
      end
      nvec++;
      if (wr_addr[i] !== ea[i]) begin
        nerr++;
        $display("FAIL wrap_waddr%0d: got %h want %h", i, wr_addr[i], ea[i]);
      end
      nvec++;
      if (wr_data[i] !== rep({2{32'(i + 1)}})) begin
        nerr++;
        $display("FAIL wrap_data%0d: got %h want %h", i, wr_data[i],
                 rep({2{32'(i + 1)}}));
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    bit done;
    for (int i = 0; i < 16; i++)
      fill_row(i, 64'h00030000_00020000, 64'h00010000_00010000);
    clear_logs();
    bus.base_address  = 20'd0;
    bus.vector_length = 20'd16;
    bus.alpha         = 64'h00010000_00000000;
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    nvec++;
    if (wr_cyc.size() != 2) begin
      nerr++;
      $display("FAIL mid_prewr: got %0d want 2", wr_cyc.size());
    end
    nvec++;
    if (bus.write_enable !== 1'b1) begin
      nerr++;
      $display("FAIL mid_we_before: got %b want 1", bus.write_enable);
    end
    #2;
    reset = 1'b1;
    #1;
    nvec++;
    if (bus.write_enable !== 1'b0) begin
      nerr++;
      $display("FAIL mid_we_async: got %b want 0", bus.write_enable);
    end
    nvec++;
    if (bus.busy !== 1'b0) begin
      nerr++;
      $display("FAIL mid_busy: got %b want 0", bus.busy);
    end
    tick();
    reset = 1'b0;
    clear_logs();
    repeat (25) tick();
    nvec++;
    if (fin_cyc.size() != 0 || wr_cyc.size() != 0) begin
      nerr++;
      $display("FAIL mid_after: got %0d finish %0d writes want 0 0",
               fin_cyc.size(), wr_cyc.size());
    end
    run_pass(20'd5, 20'd1, 64'h00010000_00000000, -1, t0, done);
    nvec++;
    if (wr_cyc.size() != 1 || wr_data[0] !== rep(64'h00020000_00010000)) begin
      nerr++;
      $display("FAIL mid_rerun_data: got %0d writes want 1 of %h",
               wr_cyc.size(), rep(64'h00020000_00010000));
    end
    nvec++;
    if (fin_cyc.size() != 1 || (done && fin_cyc[0] != t0 + 4)) begin
      nerr++;
      $display("FAIL mid_rerun_finish: got %0d pulses want 1 at %0d",
               fin_cyc.size(), t0 + 4);
    end
  endtask

  initial begin
    test_reset();
    test_unit_alpha();
    test_imag_alpha(-1);
    test_saturate();
    test_lanes();
    test_zero_len();
    test_imag_alpha(1);
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
